sdr_cmd_monitor: RTL and testbench
==================================

SDR_CMD_MONITOR -- requirements
Module: sdr_cmd_monitor

Interface
REQ-001 Parameter NUM_BANKS, 4, number of SDRAM banks tracked (power of 2, 2..8).
REQ-002 Parameter CNT_W, 16, width of each command counter.
REQ-003 Parameter T_RCD, 2, minimum ACT-to-RD/WR spacing in sdram_clk cycles (1..15).
REQ-004 Parameter T_RP, 2, minimum PRE-to-ACT spacing in sdram_clk cycles (1..15).
REQ-005 Port sdram_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port wb_rst_i  in  1  reset, synchronous to sdram_clk, active-high.
REQ-007 Ports sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n  in  1 each  SDRAM command pins.
REQ-008 Ports sdr_ba  in  $clog2(NUM_BANKS)  bank address; sdr_a10  in  1  address bit 10 (precharge-all).
REQ-009 Port clr_cnt  in  1  clear all counters.
REQ-010 Ports cmd_valid  out  1; cmd_code  out  3; cmd_bank  out  $clog2(NUM_BANKS)  decoded non-NOP command.
REQ-011 Ports act_cnt, rd_cnt, wr_cnt, ref_cnt, err_cnt  out  CNT_W each  command and error counters.
REQ-012 Port bank_open  out  NUM_BANKS  per-bank bit, 1 = bank in ACTIVE state.
REQ-013 Ports err_valid  out  1; err_code  out  3  protocol-violation pulse and code.

Function
REQ-014 Inputs are registered once; every output reflects the command sampled one cycle earlier (latency 1).
REQ-015 Decode {ras,cas,we}: 011 ACT, 101 RD, 100 WR, 010 PRE, 001 REF, 000 MRS, 110 BST, 111 NOP; sdr_cs_n=1 decodes as NOP.
REQ-016 cmd_valid is a 1-cycle pulse for every non-NOP command; cmd_code/cmd_bank hold its code/bank; all 0 on NOP.
REQ-017 Each bank runs FSM IDLE -> ACTIVATING (on ACT) -> ACTIVE (timer expiry) -> PRECHARGING (on PRE) -> IDLE (timer expiry).
REQ-018 ACT loads a per-bank timer with T_RCD-1; PRE loads it with T_RP-1; timer value 0 at load moves the FSM on the next cycle.
REQ-019 PRE with sdr_a10=1 applies to every bank not IDLE; PRE to an IDLE bank is legal and leaves it IDLE.
REQ-020 PRE to an ACTIVATING bank moves it to PRECHARGING without error.
REQ-021 Error codes: 1 RD/WR to IDLE or PRECHARGING bank; 2 ACT to ACTIVATING or ACTIVE bank; 3 RD/WR to ACTIVATING bank (tRCD); 4 ACT to PRECHARGING bank (tRP); 5 REF/MRS with any bank not IDLE.
REQ-022 err_valid pulses in the same cycle as the offending cmd_valid; err_code is 0 when err_valid is 0.
REQ-023 An erroneous command still updates bank state per REQ-017 except: error 1 leaves state unchanged; errors 2 and 4 reload the ACT timer and enter ACTIVATING.
REQ-024 Counters increment by 1 per matching command (err_cnt per err_valid) and saturate at 2^CNT_W-1.
REQ-025 clr_cnt zeroes all counters next cycle; a command counted in the same cycle is discarded (clear wins); bank state unaffected.

Reset
REQ-026 wb_rst_i=1 at a rising edge: all banks IDLE, timers 0, all counters 0, cmd_valid/err_valid/cmd_code/cmd_bank/err_code/bank_open 0.
REQ-027 Reset mid-sequence discards any in-flight registered command; no pulse is emitted in the cycle following reset.

Structure
REQ-028 Package sdr_mon_pkg holds the cmd_e enum (3-bit codes of REQ-015), err_e enum (REQ-021) and bank_state_e enum.
REQ-029 Sub-module sdr_bank_fsm (one bank: FSM, timer, error detect) is instantiated NUM_BANKS times via generate.

Verification
REQ-030 Reset then ACT b1, NOP, RD b1 (T_RCD=2) -> act_cnt=1, rd_cnt=1, bank_open=4'b0010, no err_valid.
REQ-031 ACT b0 then RD b0 next cycle -> err_valid with err_code=3, err_cnt=1, rd_cnt=1.
REQ-032 ACT b0, ACT b2, wait 2, PRE with a10=1, ACT b0 next cycle -> err_code=4 on second ACT b0; bank_open=0 after PRE.
REQ-033 REF with bank 3 ACTIVE -> err_code=5; REF after all banks IDLE -> ref_cnt increments, no error.
REQ-034 CNT_W=4: 17 WR commands to an ACTIVE bank -> wr_cnt holds 15; clr_cnt coincident with WR -> wr_cnt=0.
REQ-035 wb_rst_i asserted the cycle after ACT b0 -> cmd_valid stays 0 next cycle, bank_open=0, all counters 0.

Source files
------------

// File: rtl/sdr_mon_pkg.sv
// rtl/sdr_mon_pkg.sv - shared command, error and bank-state encodings for the SDRAM command monitor
package sdr_mon_pkg;

  localparam int TMR_W = 4;

  // Values are the raw {ras_n, cas_n, we_n} pin patterns
  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE       = 3'd0,
    ERR_NOT_OPEN   = 3'd1,
    ERR_DOUBLE_ACT = 3'd2,
    ERR_TRCD       = 3'd3,
    ERR_TRP        = 3'd4,
    ERR_REF_BUSY   = 3'd5
  } err_e;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_ACTIVATING,
    BS_ACTIVE,
    BS_PRECHARGING
  } bank_state_e;

  function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    return cs_n ? CMD_NOP : cmd_e'({ras_n, cas_n, we_n});
  endfunction

endpackage

// File: rtl/sdr_bank_fsm.sv
// rtl/sdr_bank_fsm.sv - one SDRAM bank: state machine, tRCD/tRP timer and per-bank error detection
module sdr_bank_fsm
  import sdr_mon_pkg::*;
#(
  parameter int T_RCD = 2,
  parameter int T_RP  = 2
) (
  input  logic clk,
  input  logic rst,
  input  cmd_e cmd,
  input  logic sel,
  output err_e err,
  output logic is_open,
  output logic is_idle
);

  bank_state_e state, state_nx, eff;
  logic [TMR_W-1:0] timer, timer_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BS_IDLE;
      timer <= '0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
    end
  end

  always_comb begin
    // An expired timer completes its transition on this edge, so a command
    // arriving now is judged against the state the bank is moving into.
    eff = state;
    if (state == BS_ACTIVATING && timer == '0) eff = BS_ACTIVE;
    if (state == BS_PRECHARGING && timer == '0) eff = BS_IDLE;

    state_nx = eff;
    timer_nx = (timer != '0) ? timer - TMR_W'(1) : '0;
    err      = ERR_NONE;

    if (sel) begin
      case (cmd)
        CMD_ACT: begin
          if (eff == BS_ACTIVATING || eff == BS_ACTIVE) err = ERR_DOUBLE_ACT;
          else if (eff == BS_PRECHARGING)               err = ERR_TRP;
          state_nx = BS_ACTIVATING;
          timer_nx = TMR_W'(T_RCD - 1);
        end
        CMD_RD, CMD_WR: begin
          if (eff == BS_IDLE || eff == BS_PRECHARGING) err = ERR_NOT_OPEN;
          else if (eff == BS_ACTIVATING)               err = ERR_TRCD;
        end
        CMD_PRE: begin
          if (eff != BS_IDLE) begin
            state_nx = BS_PRECHARGING;
            timer_nx = TMR_W'(T_RP - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign is_open = (state == BS_ACTIVE);
  assign is_idle = (eff == BS_IDLE);

endmodule

// File: rtl/sdr_cmd_monitor.sv
// rtl/sdr_cmd_monitor.sv - SDRAM command decoder, per-bank protocol checker and saturating command counters
module sdr_cmd_monitor
  import sdr_mon_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int CNT_W     = 16,
  parameter int T_RCD     = 2,
  parameter int T_RP      = 2
) (
  input  logic                         sdram_clk,
  input  logic                         wb_rst_i,
  input  logic                         sdr_cs_n,
  input  logic                         sdr_ras_n,
  input  logic                         sdr_cas_n,
  input  logic                         sdr_we_n,
  input  logic [$clog2(NUM_BANKS)-1:0] sdr_ba,
  input  logic                         sdr_a10,
  input  logic                         clr_cnt,
  output logic                         cmd_valid,
  output logic [2:0]                   cmd_code,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [CNT_W-1:0]             act_cnt,
  output logic [CNT_W-1:0]             rd_cnt,
  output logic [CNT_W-1:0]             wr_cnt,
  output logic [CNT_W-1:0]             ref_cnt,
  output logic [CNT_W-1:0]             err_cnt,
  output logic [NUM_BANKS-1:0]         bank_open,
  output logic                         err_valid,
  output logic [2:0]                   err_code
);

  localparam int BA_W = $clog2(NUM_BANKS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  cmd_e                 cmd;
  err_e                 err;
  err_e                 bank_err [NUM_BANKS];
  logic [NUM_BANKS-1:0] sel;
  logic [NUM_BANKS-1:0] idle;

  assign cmd = decode_cmd(sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n);

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    // a10 on PRE widens the target to every bank
    assign sel[i] = (sdr_ba == BA_W'(i)) || (cmd == CMD_PRE && sdr_a10);

    sdr_bank_fsm #(
      .T_RCD(T_RCD),
      .T_RP (T_RP)
    ) u_bank (
      .clk    (sdram_clk),
      .rst    (wb_rst_i),
      .cmd    (cmd),
      .sel    (sel[i]),
      .err    (bank_err[i]),
      .is_open(bank_open[i]),
      .is_idle(idle[i])
    );
  end

  always_comb begin
    err = ERR_NONE;
    if (cmd == CMD_REF || cmd == CMD_MRS) begin
      if (!(&idle)) err = ERR_REF_BUSY;
    end else begin
      err = bank_err[sdr_ba];
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (wb_rst_i) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_bank  <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
    end else begin
      cmd_valid <= (cmd != CMD_NOP);
      cmd_code  <= (cmd != CMD_NOP) ? 3'(cmd) : 3'd0;
      cmd_bank  <= (cmd != CMD_NOP) ? sdr_ba : '0;
      err_valid <= (err != ERR_NONE);
      err_code  <= 3'(err);
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (wb_rst_i || clr_cnt) begin
      act_cnt <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      ref_cnt <= '0;
      err_cnt <= '0;
    end else begin
      if (cmd == CMD_ACT && act_cnt != CNT_MAX) act_cnt <= act_cnt + CNT_W'(1);
      if (cmd == CMD_RD  && rd_cnt  != CNT_MAX) rd_cnt  <= rd_cnt  + CNT_W'(1);
      if (cmd == CMD_WR  && wr_cnt  != CNT_MAX) wr_cnt  <= wr_cnt  + CNT_W'(1);
      if (cmd == CMD_REF && ref_cnt != CNT_MAX) ref_cnt <= ref_cnt + CNT_W'(1);
      if (err != ERR_NONE && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// tb/tb_sdr_cmd_monitor.sv - table-driven scoreboard bench for sdr_cmd_monitor
module tb_sdr_cmd_monitor;
  import sdr_mon_pkg::*;

  typedef struct packed {
    logic       rst;
    logic       clr;
    cmd_e       cmd;
    logic [1:0] ba;
    logic       a10;
    logic [2:0] err;
    logic [3:0] open;
    logic [3:0] act;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] rf;
    logic [3:0] ec;
  } vec_t;

  typedef struct packed {
    logic       cv;
    logic [2:0] code;
    logic [1:0] bank;
    logic       ev;
    logic [2:0] ecode;
    logic [3:0] open;
    logic [3:0] act;
    logic [3:0] rd;
    logic [3:0] wr;
    logic [3:0] rf;
    logic [3:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0] ba = '0;
  logic       a10 = 1'b0;
  logic       clr = 1'b0;
  logic       cmd_valid, err_valid;
  logic [2:0] cmd_code, err_code;
  logic [1:0] cmd_bank;
  logic [3:0] act_cnt, rd_cnt, wr_cnt, ref_cnt, err_cnt, bank_open;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  vec_t vecs[$];

  sdr_cmd_monitor #(.NUM_BANKS(4), .CNT_W(4), .T_RCD(2), .T_RP(2)) dut (
    .sdram_clk(clk), .wb_rst_i(rst),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_a10(a10), .clr_cnt(clr),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
    .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .ref_cnt(ref_cnt), .err_cnt(err_cnt),
    .bank_open(bank_open), .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic r, input logic c, input cmd_e cm, input int b, input logic a,
                              input int e, input logic [3:0] o, input int ac, input int rdc,
                              input int wrc, input int rfc, input int ecc);
    vec_t v;
    v.rst = r; v.clr = c; v.cmd = cm; v.ba = 2'(b); v.a10 = a; v.err = 3'(e); v.open = o;
    v.act = 4'(ac); v.rd = 4'(rdc); v.wr = 4'(wrc); v.rf = 4'(rfc); v.ec = 4'(ecc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue required one entry");
      return;
    end
    e = sb.pop_front();
    chk("cmd_valid", 32'(cmd_valid), 32'(e.cv));
    chk("cmd_code",  32'(cmd_code),  32'(e.code));
    chk("cmd_bank",  32'(cmd_bank),  32'(e.bank));
    chk("err_valid", 32'(err_valid), 32'(e.ev));
    chk("err_code",  32'(err_code),  32'(e.ecode));
    chk("bank_open", 32'(bank_open), 32'(e.open));
    chk("act_cnt",   32'(act_cnt),   32'(e.act));
    chk("rd_cnt",    32'(rd_cnt),    32'(e.rd));
    chk("wr_cnt",    32'(wr_cnt),    32'(e.wr));
    chk("ref_cnt",   32'(ref_cnt),   32'(e.rf));
    chk("err_cnt",   32'(err_cnt),   32'(e.ec));
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst = v.rst; clr = v.clr; ba = v.ba; a10 = v.a10;
    if (v.cmd == CMD_NOP && $urandom_range(0, 1) == 1) begin
      cs_n = 1'b1;
      {ras_n, cas_n, we_n} = 3'($urandom);
    end else begin
      cs_n = 1'b0;
      {ras_n, cas_n, we_n} = v.cmd;
    end
    e.cv    = !v.rst && (v.cmd != CMD_NOP);
    e.code  = e.cv ? 3'(v.cmd) : 3'd0;
    e.bank  = e.cv ? v.ba : 2'd0;
    e.ev    = (v.err != 3'd0);
    e.ecode = v.err;
    e.open  = v.open;
    e.act = v.act; e.rd = v.rd; e.wr = v.wr; e.rf = v.rf; e.ec = v.ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    //                rst clr cmd     ba a10 err open     act rd wr rf ec
    vecs.push_back(mk(1, 0, CMD_NOP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_ACT, 1, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_RD,  1, 0, 0, 4'b0010, 1, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, CMD_NOP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_ACT, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_RD,  0, 0, 3, 4'b0000, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 0, CMD_NOP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_ACT, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_ACT, 2, 0, 0, 4'b0000, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0001, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0101, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_PRE, 3, 1, 0, 4'b0000, 2, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_ACT, 0, 0, 4, 4'b0000, 3, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, CMD_ACT, 1, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_ACT, 3, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b1000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_REF, 0, 0, 5, 4'b1000, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, CMD_PRE, 3, 0, 0, 4'b0000, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0000, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, CMD_REF, 0, 0, 0, 4'b0000, 1, 0, 0, 2, 1));
    vecs.push_back(mk(1, 0, CMD_NOP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, CMD_RD,  2, 0, 1, 4'b0000, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, CMD_ACT, 2, 0, 0, 4'b0000, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, CMD_PRE, 2, 0, 0, 4'b0000, 1, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, CMD_ACT, 2, 0, 4, 4'b0000, 2, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0000, 2, 1, 0, 0, 2));
    vecs.push_back(mk(0, 0, CMD_WR,  2, 0, 0, 4'b0100, 2, 1, 1, 0, 2));
    vecs.push_back(mk(0, 0, CMD_ACT, 2, 0, 2, 4'b0000, 3, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, CMD_MRS, 0, 0, 5, 4'b0000, 3, 1, 1, 0, 4));
    vecs.push_back(mk(0, 0, CMD_BST, 1, 0, 0, 4'b0100, 3, 1, 1, 0, 4));
    vecs.push_back(mk(0, 1, CMD_NOP, 0, 0, 0, 4'b0100, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // write counter saturation with bank 2 open, then clear racing a counted write
    for (int i = 1; i <= 17; i++)
      apply(mk(0, 0, CMD_WR, 2, 0, 0, 4'b0100, 0, 0, (i > 15) ? 15 : i, 0, 0));
    apply(mk(0, 1, CMD_WR, 2, 0, 0, 4'b0100, 0, 0, 0, 0, 0));

    // reset the cycle after an ACT drops everything and emits no pulse afterwards
    apply(mk(0, 0, CMD_ACT, 0, 0, 0, 4'b0100, 1, 0, 0, 0, 0));
    apply(mk(1, 0, CMD_NOP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));
    apply(mk(0, 0, CMD_NOP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
